// File: rtl/ecc_pkg.sv
// Shared types and constants for the ECC point datapath.
// ECC_J2A_TIMEOUT_EN enables the inverter iteration bound.
package ecc_pkg;

   typedef enum logic [2:0] {
      IDLE,
      INV,
      M1,
      M2,
      M3,
      M4,
      DONE
   } j2a_state_t;

   function automatic int INV_MAX_CYCLES(input int len);
      return 4 * len;
   endfunction

endpackage

// File: rtl/mod_inv_bin.sv
// Binary extended-Euclid inverter, one step per cycle.
// ECC_J2A_TIMEOUT_EN bounds the step count and raises timeout.
module mod_inv_bin
   import ecc_pkg::*;
#(
   parameter int LEN = 256
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           start,
   input  logic [LEN-1:0] z,
   input  logic [LEN-1:0] p,
   output logic           busy,
   output logic           done,
   output logic [LEN-1:0] zinv,
   output logic           timeout
);

   logic [LEN-1:0] u, v, x1, x2;
   logic [LEN-1:0] u_n, v_n, x1_n, x2_n;
   logic           u_one, v_one;

   assign u_one = (u == LEN'(1));
   assign v_one = (v == LEN'(1));
   assign done  = busy & (u_one | v_one);
   assign zinv  = u_one ? x1 : x2;

`ifdef ECC_J2A_TIMEOUT_EN
   localparam int MAXC = INV_MAX_CYCLES(LEN);
   localparam int CW   = $clog2(MAXC);
   logic [CW-1:0] cnt;

   assign timeout = busy & ~(u_one | v_one) & (cnt == CW'(MAXC - 1));

   always_ff @(posedge clk) begin
      if (rst || start)
         cnt <= '0;
      else if (busy)
         cnt <= cnt + CW'(1);
   end
`else
   assign timeout = 1'b0;
`endif

   // Halving keeps x congruent by adding p first when x is odd
   always_comb begin
      u_n  = u;
      v_n  = v;
      x1_n = x1;
      x2_n = x2;
      if (!u[0]) begin
         u_n  = u >> 1;
         x1_n = x1[0] ? LEN'(({1'b0, x1} + {1'b0, p}) >> 1) : x1 >> 1;
      end else if (!v[0]) begin
         v_n  = v >> 1;
         x2_n = x2[0] ? LEN'(({1'b0, x2} + {1'b0, p}) >> 1) : x2 >> 1;
      end else if (u >= v) begin
         u_n  = u - v;
         x1_n = (x1 >= x2) ? x1 - x2 : x1 - x2 + p;
      end else begin
         v_n  = v - u;
         x2_n = (x2 >= x1) ? x2 - x1 : x2 - x1 + p;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         busy <= 1'b0;
         u    <= '0;
         v    <= '0;
         x1   <= '0;
         x2   <= '0;
      end else if (start) begin
         busy <= 1'b1;
         u    <= z;
         v    <= p;
         x1   <= LEN'(1);
         x2   <= '0;
      end else if (busy) begin
         if (done || timeout) begin
            busy <= 1'b0;
         end else begin
            u  <= u_n;
            v  <= v_n;
            x1 <= x1_n;
            x2 <= x2_n;
         end
      end
   end

endmodule

// File: rtl/mod_mul.sv
// Single-cycle modular multiplier: two Montgomery reductions,
// the second by R^2 mod p, yield the plain product a*b mod p.
module mod_mul #(
   parameter int LEN = 256
) (
   input  logic [LEN-1:0] a,
   input  logic [LEN-1:0] b,
   input  logic [LEN-1:0] p,
   input  logic [LEN-1:0] p_prime,
   input  logic [LEN-1:0] r2_mod_p,
   output logic [LEN-1:0] r
);

   function automatic logic [LEN-1:0] redc(
      input logic [2*LEN-1:0] t,
      input logic [LEN-1:0]   n,
      input logic [LEN-1:0]   np
   );
      logic [LEN-1:0]   m;
      logic [2*LEN:0]   s;
      logic [LEN:0]     u;
      m = t[LEN-1:0] * np;
      s = {1'b0, t} + ((2*LEN+1)'(m) * (2*LEN+1)'(n));
      u = (LEN+1)'(s >> LEN);
      return LEN'((u >= {1'b0, n}) ? u - {1'b0, n} : u);
   endfunction

   logic [2*LEN-1:0] t1;
   logic [LEN-1:0]   r1;
   logic [2*LEN-1:0] t2;

   always_comb begin
      t1 = (2*LEN)'(a) * (2*LEN)'(b);
      r1 = redc(t1, p, p_prime);
      t2 = (2*LEN)'(r1) * (2*LEN)'(r2_mod_p);
      r  = redc(t2, p, p_prime);
   end

endmodule

// File: rtl/jacobian_to_affine.sv
// Jacobian (X,Y,Z) to affine (X/Z^2, Y/Z^3) mod p.
// ECC_J2A_TIMEOUT_EN reports a stuck inversion through err.
module jacobian_to_affine
   import ecc_pkg::*;
#(
   parameter int LEN = 256
) (
   input  logic           clk,
   input  logic           rst,
   input  logic [LEN-1:0] p,
   input  logic [LEN-1:0] p_prime,
   input  logic [LEN-1:0] r2_mod_p,
   input  logic           in_valid,
   output logic           in_ready,
   input  logic [LEN-1:0] px,
   input  logic [LEN-1:0] py,
   input  logic [LEN-1:0] pz,
   output logic           out_valid,
   input  logic           out_ready,
   output logic [LEN-1:0] ax,
   output logic [LEN-1:0] ay,
   output logic           inf,
   output logic           err
);

   j2a_state_t state, state_n;

   logic [LEN-1:0] x_q, y_q, zinv_q, zi2_q, zi3_q;
   logic [LEN-1:0] mul_a, mul_b, mul_r, inv_zinv;
   logic           accept, z_zero;
   logic           inv_busy, inv_done, inv_timeout;

   assign in_ready  = (state == IDLE);
   assign out_valid = (state == DONE);
   assign accept    = in_valid & in_ready;
   assign z_zero    = (pz == '0);

   mod_inv_bin #(.LEN(LEN)) u_inv (
      .clk     (clk),
      .rst     (rst),
      .start   (accept & ~z_zero),
      .z       (pz),
      .p       (p),
      .busy    (inv_busy),
      .done    (inv_done),
      .zinv    (inv_zinv),
      .timeout (inv_timeout)
   );

   always_comb begin
      mul_a = '0;
      mul_b = '0;
      unique case (state)
         M1:      begin mul_a = zinv_q; mul_b = zinv_q; end
         M2:      begin mul_a = zi2_q;  mul_b = zinv_q; end
         M3:      begin mul_a = x_q;    mul_b = zi2_q;  end
         M4:      begin mul_a = y_q;    mul_b = zi3_q;  end
         default: ;
      endcase
   end

   mod_mul #(.LEN(LEN)) u_mul (
      .a        (mul_a),
      .b        (mul_b),
      .p        (p),
      .p_prime  (p_prime),
      .r2_mod_p (r2_mod_p),
      .r        (mul_r)
   );

   always_ff @(posedge clk) begin
      if (rst)
         state <= IDLE;
      else
         state <= state_n;
   end

   always_comb begin
      state_n = state;
      unique case (state)
         IDLE: if (accept) state_n = z_zero ? DONE : INV;
         INV: begin
            if (inv_busy && inv_done)
               state_n = M1;
            else if (inv_timeout)
               state_n = DONE;
         end
         M1:   state_n = M2;
         M2:   state_n = M3;
         M3:   state_n = M4;
         M4:   state_n = DONE;
         DONE: if (out_ready) state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         x_q    <= '0;
         y_q    <= '0;
         zinv_q <= '0;
         zi2_q  <= '0;
         zi3_q  <= '0;
         ax     <= '0;
         ay     <= '0;
         inf    <= 1'b0;
         err    <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               if (accept) begin
                  x_q <= px;
                  y_q <= py;
                  inf <= z_zero;
                  err <= 1'b0;
                  if (z_zero) begin
                     ax <= '0;
                     ay <= '0;
                  end
               end
            end
            INV: begin
               if (inv_busy && inv_done) begin
                  zinv_q <= inv_zinv;
               end else if (inv_timeout) begin
                  err <= 1'b1;
                  ax  <= '0;
                  ay  <= '0;
               end
            end
            M1:      zi2_q <= mul_r;
            M2:      zi3_q <= mul_r;
            M3:      ax    <= mul_r;
            M4:      ay    <= mul_r;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_jacobian_to_affine.sv
// Directed bench for jacobian_to_affine at LEN=8, p=23.
// Model computes x/Z^2, y/Z^3 by brute-force inverse search.
module tb_jacobian_to_affine;

   localparam int LEN = 8;

   logic           clk = 1'b0;
   logic           rst;
   logic [LEN-1:0] p, p_prime, r2_mod_p;
   logic           in_valid, in_ready;
   logic [LEN-1:0] px, py, pz;
   logic           out_valid, out_ready;
   logic [LEN-1:0] ax, ay;
   logic           inf, err;

   int checks = 0;
   int errors = 0;

   int e_ax, e_ay, e_inf, e_err;
   bit pending = 0;
   int lat;

   always #5 clk = ~clk;

   jacobian_to_affine #(.LEN(LEN)) dut (
      .clk       (clk),
      .rst       (rst),
      .p         (p),
      .p_prime   (p_prime),
      .r2_mod_p  (r2_mod_p),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .px        (px),
      .py        (py),
      .pz        (pz),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .ax        (ax),
      .ay        (ay),
      .inf       (inf),
      .err       (err)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   function automatic int m_inv(input int z, input int n);
      for (int k = 1; k < n; k++)
         if ((z * k) % n == 1) return k;
      return -1;
   endfunction

   task automatic set_model(input int x, input int y, input int z);
      int n, zi;
      n = int'(p);
      zi = m_inv(z, n);
      if (z == 0) begin
         e_ax = 0; e_ay = 0; e_inf = 1; e_err = 0;
      end else if (zi < 0) begin
         e_ax = 0; e_ay = 0; e_inf = 0; e_err = 1;
      end else begin
         e_ax  = (x * ((zi * zi) % n)) % n;
         e_ay  = (y * ((zi * zi * zi) % n)) % n;
         e_inf = 0;
         e_err = 0;
      end
      pending = 1;
   endtask

   always @(negedge clk) begin
      if (pending && out_valid && !rst) begin
         chk("ax", ax, e_ax);
         chk("ay", ay, e_ay);
         chk("inf", inf, e_inf);
         chk("err", err, e_err);
      end
   end

   task automatic accept(input int x, input int y, input int z);
      int n = 0;
      @(negedge clk);
      while (!in_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      chk("accept_ready", in_ready, 1);
      set_model(x, y, z);
      px = LEN'(x);
      py = LEN'(y);
      pz = LEN'(z);
      in_valid = 1;
      @(posedge clk);
      #1 in_valid = 0;
   endtask

   task automatic wait_out(output int l);
      l = 1;
      @(negedge clk);
      while (!out_valid && l < 100) begin
         @(negedge clk);
         l++;
      end
      chk("out_valid_seen", out_valid, 1);
   endtask

   task automatic finish_out();
      @(posedge clk);
      #1 pending = 0;
      @(negedge clk);
      chk("out_valid_drop", out_valid, 0);
      chk("in_ready_back", in_ready, 1);
   endtask

   initial begin
      rst = 1; p = 23; p_prime = 89; r2_mod_p = 9;
      in_valid = 0; out_ready = 1; px = 0; py = 0; pz = 0;
      repeat (3) @(posedge clk);
      #1 rst = 0;
      @(negedge clk);
      chk("rst_in_ready", in_ready, 1);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_ax", ax, 0);
      chk("rst_ay", ay, 0);
      chk("rst_inf", inf, 0);
      chk("rst_err", err, 0);

      accept(5, 7, 1);
      wait_out(lat);
      chk("lat_z1", lat, 6);
      chk("z1_ax_lit", ax, 5);
      chk("z1_ay_lit", ay, 7);
      finish_out();

      accept(8, 8, 2);
      wait_out(lat);
      chk("lat_z2", lat, 7);
      chk("zinv_probe", dut.zinv_q, 12);
      chk("z2_ax_lit", ax, 2);
      chk("z2_ay_lit", ay, 1);
      finish_out();

      accept(3, 4, 0);
      wait_out(lat);
      chk("lat_inf", lat, 1);
      chk("inf_lit", inf, 1);
      finish_out();

      out_ready = 0;
      accept(8, 8, 2);
      wait_out(lat);
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         chk("bp_in_ready", in_ready, 0);
         chk("bp_out_valid", out_valid, 1);
         chk("bp_ax_lit", ax, 2);
      end
      out_ready = 1;
      @(posedge clk);
      #1 pending = 0;
      set_model(5, 7, 1);
      px = 5; py = 7; pz = 1; in_valid = 1;
      @(negedge clk);
      chk("bp_ready_next", in_ready, 1);
      chk("bp_valid_drop", out_valid, 0);
      @(posedge clk);
      #1 in_valid = 0;
      wait_out(lat);
      chk("lat_after_bp", lat, 6);
      finish_out();

      accept(10, 3, 5);
      wait_out(lat);
      chk("lat_bound_a", lat <= 37, 1);
      finish_out();
      accept(22, 22, 22);
      wait_out(lat);
      chk("lat_bound_b", lat <= 37, 1);
      finish_out();
      accept(1, 0, 17);
      wait_out(lat);
      chk("lat_bound_c", lat <= 37, 1);
      finish_out();
      accept(0, 9, 3);
      wait_out(lat);
      chk("lat_bound_d", lat <= 37, 1);
      finish_out();

      accept(8, 8, 2);
      pending = 0;
      @(posedge clk);
      @(posedge clk);
      #1 rst = 1;
      @(posedge clk);
      #1 rst = 0;
      @(negedge clk);
      chk("midrst_in_ready", in_ready, 1);
      chk("midrst_out_valid", out_valid, 0);
      accept(5, 7, 1);
      wait_out(lat);
      chk("lat_after_rst", lat, 6);
      finish_out();

`ifdef ECC_J2A_TIMEOUT_EN
      p = 21;
      accept(4, 5, 7);
      wait_out(lat);
      chk("lat_timeout", lat <= 33, 1);
      chk("timeout_err_lit", err, 1);
      chk("timeout_ax_lit", ax, 0);
      finish_out();
      p = 23;
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
